// File: rtl/rgmii_egress_arbiter.sv
// Frame-level arbiter sharing one RGMII byte shipper among NUM_PORTS egress queues.
// Define RGMII_EGRESS_ARBITER_STRICT_PRIORITY_EN for fixed lowest-index-wins arbitration.
module rgmii_egress_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int HOLDOFF_CYCLES  = 8,
    parameter int MAX_FRAME_BYTES = 1536
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_PORTS*9-1:0] request_data,
    input  logic [NUM_PORTS-1:0]   request_data_enable,
    input  logic [NUM_PORTS-1:0]   request_last,
    output logic [NUM_PORTS-1:0]   request_data_ready,
    output logic [8:0]             ship_data,
    output logic                   ship_data_enable,
    input  logic                   ship_data_ready,
    output logic [2:0]             grant,
    output logic                   grant_valid,
    output logic                   frame_error
);
    // state     | meaning
    // S_IDLE    | searching for a port presenting a start byte
    // S_FORWARD | granted port's frame streams to the shipper
    // S_HOLDOFF | enforced gap so the shipper closes the frame
    typedef enum logic [1:0] {S_IDLE, S_FORWARD, S_HOLDOFF} state_t;

    localparam logic [15:0] MAX_COUNT = 16'(MAX_FRAME_BYTES);
    localparam logic [7:0]  HOLD_LOAD = 8'(HOLDOFF_CYCLES - 1);

    state_t      state, state_next;
    logic [2:0]  grant_next, rr_pointer, rr_next, pick;
    logic        grant_valid_next, frame_error_next, found;
    logic [15:0] byte_count, count_next, count_inc;
    logic [7:0]  holdoff_count, holdoff_next;
    logic [8:0]  cur_byte;
    logic        cur_en, cur_last;
    logic [NUM_PORTS-1:0] candidate;
    int          idx;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            grant         <= 3'd0;
            grant_valid   <= 1'b0;
            frame_error   <= 1'b0;
            rr_pointer    <= 3'(NUM_PORTS - 1);
            byte_count    <= 16'd0;
            holdoff_count <= 8'd0;
        end else begin
            state         <= state_next;
            grant         <= grant_next;
            grant_valid   <= grant_valid_next;
            frame_error   <= frame_error_next;
            rr_pointer    <= rr_next;
            byte_count    <= count_next;
            holdoff_count <= holdoff_next;
        end
    end

    always_comb begin
        state_next         = state;
        grant_next         = grant;
        grant_valid_next   = grant_valid;
        frame_error_next   = 1'b0;
        rr_next            = rr_pointer;
        count_next         = byte_count;
        holdoff_next       = holdoff_count;
        ship_data          = 9'd0;
        ship_data_enable   = 1'b0;
        request_data_ready = '0;
        cur_byte           = 9'd0;
        cur_en             = 1'b0;
        cur_last           = 1'b0;
        found              = 1'b0;
        pick               = 3'd0;
        idx                = 0;
        count_inc          = (byte_count == 16'hFFFF) ? byte_count : byte_count + 16'd1;

        for (int p = 0; p < NUM_PORTS; p++) begin
            candidate[p] = request_data_enable[p] && request_data[p*9+8];
            if (grant == 3'(p)) begin
                cur_byte = request_data[p*9 +: 9];
                cur_en   = request_data_enable[p];
                cur_last = request_last[p];
            end
            // Orphan continuation bytes are discarded so every port resyncs on a start byte.
            if (!(state == S_FORWARD && grant == 3'(p)) &&
                request_data_enable[p] && !request_data[p*9+8])
                request_data_ready[p] = 1'b1;
        end

        case (state)
            S_IDLE: begin
                for (int k = 0; k < NUM_PORTS; k++) begin
`ifdef RGMII_EGRESS_ARBITER_STRICT_PRIORITY_EN
                    idx = k;
`else
                    idx = (int'(rr_pointer) + 1 + k) % NUM_PORTS;
`endif
                    for (int p = 0; p < NUM_PORTS; p++)
                        if (p == idx && !found && candidate[p]) begin
                            found = 1'b1;
                            pick  = 3'(p);
                        end
                end
                if (found) begin
                    grant_next       = pick;
                    grant_valid_next = 1'b1;
`ifndef RGMII_EGRESS_ARBITER_STRICT_PRIORITY_EN
                    rr_next          = pick;
`endif
                    count_next       = 16'd0;
                    state_next       = S_FORWARD;
                end
            end
            S_FORWARD: begin
                if (cur_en && cur_byte[8] && byte_count != 16'd0) begin
                    // Nested start: leave it queued, it opens the port's next frame.
                    frame_error_next = 1'b1;
                    grant_valid_next = 1'b0;
                    holdoff_next     = HOLD_LOAD;
                    state_next       = S_HOLDOFF;
                end else if (cur_en) begin
                    ship_data_enable = 1'b1;
                    ship_data        = cur_byte;
                    if (ship_data_ready) begin
                        for (int p = 0; p < NUM_PORTS; p++)
                            if (grant == 3'(p)) request_data_ready[p] = 1'b1;
                        count_next = count_inc;
                        if (cur_last || count_inc == MAX_COUNT) begin
                            frame_error_next = !cur_last;
                            grant_valid_next = 1'b0;
                            holdoff_next     = HOLD_LOAD;
                            state_next       = S_HOLDOFF;
                        end
                    end
                end
            end
            S_HOLDOFF: begin
                if (holdoff_count == 8'd0) state_next = S_IDLE;
                else holdoff_next = holdoff_count - 8'd1;
            end
            default: state_next = S_IDLE;
        endcase

        if (!reset_n) begin
            ship_data          = 9'd0;
            ship_data_enable   = 1'b0;
            request_data_ready = '0;
        end
    end
endmodule

// File: tb/tb_rgmii_egress_arbiter.sv
// Bench for rgmii_egress_arbiter: queue-based port model, frame-level reference model,
// per-cycle compare plus literal frame/grant expectations.
module tb_rgmii_egress_arbiter;
    localparam int NP = 4, HOLD = 8, MAXB = 4;

    logic          clock = 1'b0, reset_n = 1'b0, sdr = 1'b1;
    logic [NP*9-1:0] request_data = '0;
    logic [NP-1:0] request_data_enable = '0, request_last = '0, request_data_ready;
    logic [8:0]    ship_data;
    logic          ship_data_enable, grant_valid, frame_error;
    logic [2:0]    grant;

    rgmii_egress_arbiter #(.NUM_PORTS(NP), .HOLDOFF_CYCLES(HOLD), .MAX_FRAME_BYTES(MAXB)) dut (
        .clock(clock), .reset_n(reset_n), .request_data(request_data),
        .request_data_enable(request_data_enable), .request_last(request_last),
        .request_data_ready(request_data_ready), .ship_data(ship_data),
        .ship_data_enable(ship_data_enable), .ship_data_ready(sdr),
        .grant(grant), .grant_valid(grant_valid), .frame_error(frame_error));

    always #5 clock = ~clock;

    int checks = 0, errors = 0, cyc = 0;
    bit chk_on = 0;

    // Port queues: {last, sof, data}
    logic [9:0] pmem [NP][64];
    int phd [NP], ptl [NP];
    logic [NP-1:0] pop = '0;

    // Reference model state
    bit m_act = 0, m_err = 0;
    int m_port = 0, m_cnt = 0, m_gap = 0, m_rr = NP - 1, err_events = 0;
    int drained [NP];
    logic [8:0] shipped[$];
    int ship_cyc[$], glog[$];

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endfunction

    function automatic bit has(int p);
        return phd[p] < ptl[p];
    endfunction

    function automatic logic [9:0] head(int p);
        return has(p) ? pmem[p][phd[p]] : 10'd0;
    endfunction

    function automatic bit quiet();
        for (int p = 0; p < NP; p++) if (has(p)) return 0;
        return !m_act && m_gap == 0;
    endfunction

    always @(negedge clock) begin
        logic [NP-1:0] e_ready;
        logic [8:0]    e_data;
        logic [9:0]    h;
        bit            e_en;
        int            p;
        cyc++;
        for (int i = 0; i < NP; i++) if (pop[i]) phd[i]++;
        for (int i = 0; i < NP; i++) begin
            request_data[i*9 +: 9]  = head(i)[8:0];
            request_data_enable[i]  = has(i);
            request_last[i]         = has(i) && head(i)[9];
        end
        #1;
        e_ready = '0; e_en = 0; e_data = '0;
        h = head(m_port);
        if (reset_n) begin
            for (int i = 0; i < NP; i++)
                if (has(i) && !(m_act && m_port == i) && !head(i)[8]) e_ready[i] = 1'b1;
            if (m_act && has(m_port) && !(h[8] && m_cnt > 0)) begin
                e_en = 1; e_data = h[8:0];
                if (sdr) e_ready[m_port] = 1'b1;
            end
        end
        if (chk_on) begin
            chk("ship_data_enable", ship_data_enable, e_en);
            chk("ship_data", ship_data, e_data);
            chk("request_data_ready", request_data_ready, e_ready);
            chk("grant_valid", grant_valid, m_act);
            chk("grant", grant, m_port);
            chk("frame_error", frame_error, m_err);
        end
        pop = e_ready;
        if (!reset_n) begin
            m_act = 0; m_port = 0; m_cnt = 0; m_gap = 0; m_rr = NP - 1; m_err = 0;
        end else begin
            m_err = 0;
            for (int i = 0; i < NP; i++)
                if (e_ready[i] && !(m_act && m_port == i)) drained[i]++;
            if (m_act) begin
                if (has(m_port) && h[8] && m_cnt > 0) begin
                    m_err = 1; err_events++; m_act = 0; m_gap = HOLD;
                end else if (e_en && sdr) begin
                    shipped.push_back(e_data);
                    ship_cyc.push_back(cyc);
                    m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
                    if (h[9]) begin
                        m_act = 0; m_gap = HOLD;
                    end else if (m_cnt == MAXB) begin
                        m_err = 1; err_events++; m_act = 0; m_gap = HOLD;
                    end
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else begin
                for (int k = 0; k < NP && !m_act; k++) begin
`ifdef RGMII_EGRESS_ARBITER_STRICT_PRIORITY_EN
                    p = k;
`else
                    p = (m_rr + 1 + k) % NP;
`endif
                    if (has(p) && head(p)[8]) begin
                        m_act = 1; m_port = p; m_cnt = 0; glog.push_back(p);
`ifndef RGMII_EGRESS_ARBITER_STRICT_PRIORITY_EN
                        m_rr = p;
`endif
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic push1(int p, logic [9:0] v);
        pmem[p][ptl[p]] = v;
        ptl[p]++;
    endtask

    task automatic push_frame(int p, int n, logic [9:0] b [8]);
        for (int i = 0; i < n; i++) push1(p, b[i]);
    endtask

    task automatic wait_quiet(string nm, int max);
        int n = 0;
        do begin step(); n++; end while (!quiet() && n < max);
        checks++;
        if (!quiet()) begin
            errors++;
            $display("FAIL %s timeout: not idle after %0d cycles", nm, max);
        end
    endtask

    task automatic check_shipped(string nm, int n, logic [8:0] e [8]);
        chk({nm, "_len"}, shipped.size(), n);
        for (int i = 0; i < n && i < shipped.size(); i++) chk(nm, shipped[i], e[i]);
    endtask

    task automatic check_grants(string nm, int n, int e [8]);
        chk({nm, "_len"}, glog.size(), n);
        for (int i = 0; i < n && i < glog.size(); i++) chk(nm, glog[i], e[i]);
    endtask

    task automatic clear_logs();
        shipped.delete(); ship_cyc.delete(); glog.delete();
    endtask

    initial begin
        int e0, d1, n;
        for (int i = 0; i < NP; i++) begin phd[i] = 0; ptl[i] = 0; drained[i] = 0; end
        step(); chk_on = 1; step();
        chk("reset_grant_valid", grant_valid, 0);
        chk("reset_grant", grant, 0);
        chk("reset_ship_enable", ship_data_enable, 0);
        chk("reset_frame_error", frame_error, 0);
        reset_n = 1;

        // Two 4-byte frames; last coincides with the byte limit -> normal completion
        push_frame(0, 4, '{10'h1AA, 10'h011, 10'h022, 10'h233, 0, 0, 0, 0});
        push_frame(2, 4, '{10'h1AA, 10'h011, 10'h022, 10'h233, 0, 0, 0, 0});
        wait_quiet("two_frames", 200);
        check_shipped("two_frames", 8, '{9'h1AA, 9'h011, 9'h022, 9'h033, 9'h1AA, 9'h011, 9'h022, 9'h033});
        check_grants("two_frames_grant", 2, '{0, 2, 0, 0, 0, 0, 0, 0});
        if (ship_cyc.size() == 8) begin
            chk("back_to_back_bytes", ship_cyc[1] - ship_cyc[0], 1);
            chk("interframe_gap", ship_cyc[4] - ship_cyc[3], HOLD + 2);
        end
        chk("two_frames_no_error", err_events, 0);

        // Arbitration order with every port holding two frames
        reset_n = 0; step(); reset_n = 1; clear_logs();
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < NP; p++) begin
                push1(p, 10'(10'h100 + p * 16 + f));
                push1(p, 10'(10'h280 + p * 16 + f));
            end
        wait_quiet("rr_order", 400);
`ifdef RGMII_EGRESS_ARBITER_STRICT_PRIORITY_EN
        check_grants("grant_order", 8, '{0, 0, 1, 1, 2, 2, 3, 3});
`else
        check_grants("grant_order", 8, '{0, 1, 2, 3, 0, 1, 2, 3});
`endif

        // Shipper backpressure mid-frame
        clear_logs();
        push_frame(1, 4, '{10'h1AA, 10'h011, 10'h022, 10'h233, 0, 0, 0, 0});
        n = 0;
        while (shipped.size() < 2 && n < 50) begin step(); n++; end
        chk("stall_reached", shipped.size(), 2);
        sdr = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_ship_data", ship_data, 9'h022);
            chk("stall_ship_enable", ship_data_enable, 1);
            chk("stall_ready", request_data_ready[1], 0);
        end
        sdr = 1;
        wait_quiet("stall", 100);
        check_shipped("stall", 4, '{9'h1AA, 9'h011, 9'h022, 9'h033, 0, 0, 0, 0});

        // Overrun: 6 bytes without last, limit 4
        clear_logs(); e0 = err_events; d1 = drained[1];
        push_frame(1, 6, '{10'h1B0, 10'h0B1, 10'h0B2, 10'h0B3, 10'h0B4, 10'h0B5, 0, 0});
        wait_quiet("overrun", 100);
        check_shipped("overrun", 4, '{9'h1B0, 9'h0B1, 9'h0B2, 9'h0B3, 0, 0, 0, 0});
        chk("overrun_errors", err_events - e0, 1);
        chk("overrun_drained", drained[1] - d1, 2);

        // Nested start on port 3 at byte 3
        clear_logs(); e0 = err_events;
        push_frame(3, 5, '{10'h1A0, 10'h0B1, 10'h1F0, 10'h0C2, 10'h2D3, 0, 0, 0});
        wait_quiet("nested", 100);
        check_shipped("nested", 5, '{9'h1A0, 9'h0B1, 9'h1F0, 9'h0C2, 9'h0D3, 0, 0, 0});
        check_grants("nested_grant", 2, '{3, 3, 0, 0, 0, 0, 0, 0});
        chk("nested_errors", err_events - e0, 1);

        // Reset in the middle of a frame
        clear_logs();
        push_frame(0, 4, '{10'h1AA, 10'h011, 10'h022, 10'h233, 0, 0, 0, 0});
        n = 0;
        while (!(m_act && shipped.size() >= 1) && n < 50) begin step(); n++; end
        chk("midframe_reached", m_act, 1);
        reset_n = 0; step();
        chk("midreset_grant_valid", grant_valid, 0);
        chk("midreset_ship_enable", ship_data_enable, 0);
        chk("midreset_ready", request_data_ready, 0);
        chk("midreset_grant", grant, 0);
        reset_n = 1;
        wait_quiet("after_reset", 100);
        chk("after_reset_grants", glog.size(), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
